// File: rtl/round_robin_pesado_param.sv
// round_robin_pesado_param: weighted round-robin arbiter granting bursts of weight(q) pops per queue turn.
// Define ROUND_ROBIN_PESADO_URGENT_EN to let queues at/above URGENT_LEVEL jump the circular order at burst boundaries.
module round_robin_pesado_param #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int MAX_WEIGHT     = 64,
    parameter int COUNTER_BITS   = 4,
    parameter int URGENT_LEVEL   = 12
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enb,
    input  logic [QUEUE_QUANTITY*$clog2(MAX_WEIGHT)-1:0] pesos,
    input  logic [QUEUE_QUANTITY-1:0]              buf_empty,
    input  logic [QUEUE_QUANTITY*COUNTER_BITS-1:0] fifo_counter,
    input  logic                                   downstream_ready,
    output logic [$clog2(QUEUE_QUANTITY)-1:0]      selector,
    output logic                                   selector_enb
);
    localparam int W  = $clog2(MAX_WEIGHT);
    localparam int SW = $clog2(QUEUE_QUANTITY);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t              state;
    logic [SW-1:0]       ptr;
    logic [W-1:0]        credit;
    logic [QUEUE_QUANTITY-1:0] eligible;
    logic                found;
    logic [SW-1:0]       pick;
    logic [SW-1:0]       cand;
    logic                cont;

    always_comb begin
        for (int i = 0; i < QUEUE_QUANTITY; i++)
            eligible[i] = !buf_empty[i] && (pesos[i*W +: W] != '0);
    end

    assign cont = (state == SERVE) && (credit != '0) && !buf_empty[ptr];

    // Nearest eligible queue after ptr wins; ptr itself is tried last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= QUEUE_QUANTITY; k++) begin
            cand = SW'((int'(ptr) + k) % QUEUE_QUANTITY);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
`ifdef ROUND_ROBIN_PESADO_URGENT_EN
        for (int i = QUEUE_QUANTITY - 1; i >= 0; i--) begin
            if (eligible[i] && int'(fifo_counter[i*COUNTER_BITS +: COUNTER_BITS]) >= URGENT_LEVEL) begin
                found = 1'b1;
                pick  = SW'(i);
            end
        end
`endif
    end

`ifndef ROUND_ROBIN_PESADO_URGENT_EN
    logic unused_counter;
    assign unused_counter = ^fifo_counter;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            selector     <= '0;
            selector_enb <= 1'b0;
            ptr          <= SW'(QUEUE_QUANTITY - 1);
            credit       <= '0;
            state        <= IDLE;
        end else if (!enb || !downstream_ready) begin
            selector_enb <= 1'b0;
        end else if (cont) begin
            selector     <= ptr;
            selector_enb <= 1'b1;
            credit       <= credit - W'(1);
            state        <= SERVE;
        end else if (found) begin
            selector     <= pick;
            selector_enb <= 1'b1;
            ptr          <= pick;
            credit       <= pesos[pick*W +: W] - W'(1);
            state        <= SERVE;
        end else begin
            selector_enb <= 1'b0;
            credit       <= '0;
            state        <= IDLE;
        end
    end
endmodule

// File: doc/round_robin_pesado_param.md
ROUND_ROBIN_PESADO_PARAM -- requirements
Module: round_robin_pesado_param

Interface
REQ-001 SHALL have parameter QUEUE_QUANTITY, default 4, number of queues arbitrated (>=2).
REQ-002 SHALL have parameter MAX_WEIGHT, default 64; weight field width W = $clog2(MAX_WEIGHT).
REQ-003 SHALL have parameter COUNTER_BITS, default 4, width of each per-queue occupancy field.
REQ-004 SHALL have parameter URGENT_LEVEL, default 12, occupancy threshold for urgent service.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-007 SHALL have port enb, input, 1, block enable.
REQ-008 SHALL have port pesos, input, QUEUE_QUANTITY*W, weight of queue i at bits [i*W +: W].
REQ-009 SHALL have port buf_empty, input, QUEUE_QUANTITY, bit i high = queue i empty.
REQ-010 SHALL have port fifo_counter, input, QUEUE_QUANTITY*COUNTER_BITS, occupancy of queue i at [i*COUNTER_BITS +: COUNTER_BITS].
REQ-011 SHALL have port downstream_ready, input, 1, consumer can accept a grant this cycle.
REQ-012 SHALL have port selector, output, $clog2(QUEUE_QUANTITY), registered index of granted queue.
REQ-013 SHALL have port selector_enb, output, 1, registered; high = one word popped from selector's queue this cycle.

Function
REQ-014 SHALL define queue i eligible when buf_empty[i]=0 and its weight != 0; weight 0 disables the queue.
REQ-015 SHALL hold internal ptr (last-served queue), credit (W bits, grants remaining in burst) and state {IDLE, SERVE}.
REQ-016 SHALL, on an edge with enb=0 or downstream_ready=0, drive selector_enb<=0 and hold selector, ptr, credit, state.
REQ-017 SHALL, on an edge with enb=1 and downstream_ready=1, credit>0 and queue ptr non-empty, grant ptr: selector<=ptr, selector_enb<=1, credit<=credit-1, state SERVE.
REQ-018 SHALL otherwise (burst boundary) search circularly ptr+1, ptr+2, ... wrapping QUEUE_QUANTITY-1 -> 0, ptr itself last, for the first eligible queue q.
REQ-019 SHALL, when q is found, grant q on the same edge: selector<=q, selector_enb<=1, ptr<=q, credit<=weight(q)-1, state SERVE.
REQ-020 SHALL, when no queue is eligible, drive selector_enb<=0, credit<=0, state IDLE; selector holds.
REQ-021 SHALL sample a queue's weight only at its burst start; weight changes mid-burst take effect next burst.
REQ-022 SHALL end a burst early when the served queue empties; the next edge performs the boundary search.
REQ-023 SHALL make the grant visible on outputs exactly one cycle after the inputs that decided it (one register stage, no combinational input-to-output path).
REQ-024 SHALL grant a queue of weight W exactly W consecutive times per turn when it stays non-empty and downstream_ready stays high.

Reset
REQ-025 SHALL, on an edge with rst=0, set selector=0, selector_enb=0, ptr=QUEUE_QUANTITY-1, credit=0, state IDLE, regardless of enb.
REQ-026 SHALL abort any burst in progress on reset; first search after reset starts at queue 0.

Configuration
REQ-027 SHALL, with macro ROUND_ROBIN_PESADO_URGENT_EN defined, at every burst boundary grant the lowest-index eligible queue whose occupancy >= URGENT_LEVEL ahead of the circular search; bursts in progress are never preempted.
REQ-028 SHALL, without ROUND_ROBIN_PESADO_URGENT_EN, ignore fifo_counter entirely (port kept, unused).

Verification (QUEUE_QUANTITY=4, MAX_WEIGHT=64, all ready/enb high unless stated)
REQ-029 SHALL cover: weights q0..q3={1,2,3,4}, all non-empty -> selector sequence 0,1,1,2,2,2,3,3,3,3 repeating, selector_enb=1 every cycle.
REQ-030 SHALL cover: q1 weight 0 -> sequence 0,2,2,2,3,3,3,3,0 ...; q1 never granted.
REQ-031 SHALL cover: q2 (weight 3) buf_empty rises after first q2 grant -> next grant is q3, no bubble.
REQ-032 SHALL cover: downstream_ready low 3 cycles mid q3 burst -> selector_enb=0 those cycles, remaining q3 grants resume afterward with credit intact.
REQ-033 SHALL cover: all buf_empty=1 -> selector_enb=0 (IDLE); buf_empty[3] falls -> selector=3, selector_enb=1 one edge later; rst=0 mid-burst -> all outputs 0 next edge, restart at q0.
REQ-034 SHALL cover: macro defined, URGENT_LEVEL=12, fifo_counter[q2]=12 at end of q0 burst -> q2 served before q1; macro undefined -> q1 next.
